// File: rtl/opb_register_ppc2fabric_pkg.sv
// Shared definitions for the PPC-to-fabric software register and its
// reusable OPB slave acknowledge FSM.
package opb_register_ppc2fabric_pkg;

   // Byte offsets of the registers inside the decoded window
   localparam logic [31:0] REG_DATA   = 32'h0000_0000;
   localparam logic [31:0] REG_STATUS = 32'h0000_0004;
   localparam logic [31:0] REG_WCOUNT = 32'h0000_0008;

   // STATUS register bit positions (fabric numbering, bit 0 = LSB)
   localparam int STATUS_PENDING_BIT = 0;
   localparam int STATUS_OVERRUN_BIT = 1;

   // Slave acknowledge FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      GAP  = 2'd2
   } ack_state_e;

endpackage

// File: rtl/opb_register_ppc2fabric_ack_fsm.sv
// Address decode plus IDLE -> ACK -> GAP acknowledge sequencer for a
// simple OPB slave. The GAP cycle keeps a select that stays high from
// being acknowledged twice in a row.
//
// Handshake: a transfer starts when select is high with an in-window
// address while the FSM is IDLE (start = 1 for that cycle). The next
// cycle is the ACK cycle: ack = 1 for exactly one cycle, during which the
// master must still hold address, RNW, BE and data stable. The slave
// commits writes at the end of the ACK cycle.
module opb_slave_ack_fsm
   import opb_register_ppc2fabric_pkg::*;
#(
   parameter int                      C_OPB_AWIDTH = 32,
   parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0100_E200,
   parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0100_E2FF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [0:C_OPB_AWIDTH-1] abus,
   input  logic                    select,
   output logic                    start,
   output logic                    ack,
   output ack_state_e              state
);

   logic hit;

   // Window decode: the address is compared as an unsigned number
   always_comb begin
      hit   = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
      start = (state == IDLE) && hit;
   end

   // Three-state sequencer with a registered one-cycle ack pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ack   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  state <= ACK;
                  ack   <= 1'b1;
               end
            end
            ACK: begin
               state <= GAP;
               ack   <= 1'b0;
            end
            GAP: begin
               state <= IDLE;
               ack   <= 1'b0;
            end
            default: begin
               state <= IDLE;
               ack   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/opb_register_ppc2fabric.sv
// OPB slave register carrying a 32-bit word from the PPC to fabric logic.
// DATA holds the last written word, STATUS reports pending/overrun and
// WCOUNT counts DATA writes. All logic runs on OPB_Clk.
//
// User handshake: user_data_valid rises the cycle after a DATA write is
// committed; the consumer raises user_ack for one or more cycles and
// valid falls the cycle after user_ack is sampled high with valid = 1.
module opb_register_ppc2fabric
   import opb_register_ppc2fabric_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR    = 32'h0100_E200,
   parameter logic [31:0] C_HIGHADDR    = 32'h0100_E2FF,
   parameter int          C_OPB_AWIDTH  = 32,
   parameter int          C_OPB_DWIDTH  = 32,
   parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
   input  logic [0:3]              OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
   input  logic                    OPB_RNW,
   input  logic                    OPB_select,
   input  logic                    OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
   output logic                    Sl_xferAck,
   output logic                    Sl_errAck,
   output logic                    Sl_retry,
   output logic                    Sl_toutSup,
   output logic [31:0]             user_data_out,
   output logic                    user_data_valid,
   input  logic                    user_ack
);

   logic        start;
   logic        ack;
   ack_state_e  slave_state;
   logic [31:0] offset;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [31:0] wmask;
   logic [31:0] status_word;
   logic [31:0] rdata;
   logic        wr_data;
   logic        wr_status;
   logic [31:0] data_q;
   logic [31:0] wcount;
   logic        overrun;
   logic [31:0] sl_dbus_q;
   logic        unused_ok;

   opb_slave_ack_fsm #(
      .C_OPB_AWIDTH (C_OPB_AWIDTH),
      .C_BASEADDR   (C_BASEADDR),
      .C_HIGHADDR   (C_HIGHADDR)
   ) u_ack_fsm (
      .clk    (OPB_Clk),
      .rst_n  (OPB_Rst_n),
      .abus   (OPB_ABus),
      .select (OPB_select),
      .start  (start),
      .ack    (ack),
      .state  (slave_state)
   );

   // seqAddr carries no meaning for a single-beat register; the FSM state
   // is exposed by the sub-module for observation only.
   assign unused_ok = ^{OPB_seqAddr, slave_state};

   // Bus bit 0 is the MSB, so a plain vector assignment maps DBus[0] to
   // bit 31 and BE[0] to byte lane 3 (bits 31:24).
   always_comb begin
      offset = OPB_ABus - C_BASEADDR;
      wdata  = OPB_DBus;
      be     = OPB_BE;
      for (int i = 0; i < 4; i++) begin
         wmask[8*i +: 8] = {8{be[i]}};
      end
      wr_data   = ack && !OPB_RNW && (offset == REG_DATA);
      wr_status = ack && !OPB_RNW && (offset == REG_STATUS);
   end

   // Read mux; unmapped in-window offsets read as zero
   always_comb begin
      status_word                     = '0;
      status_word[STATUS_PENDING_BIT] = user_data_valid;
      status_word[STATUS_OVERRUN_BIT] = overrun;
      case (offset)
         REG_DATA:   rdata = data_q;
         REG_STATUS: rdata = status_word;
         REG_WCOUNT: rdata = wcount;
         default:    rdata = '0;
      endcase
   end

   // Registered read data: loaded when a read is accepted, zero otherwise,
   // so Sl_DBus is non-zero only during the ACK cycle
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         sl_dbus_q <= '0;
      end else if (start && OPB_RNW) begin
         sl_dbus_q <= rdata;
      end else begin
         sl_dbus_q <= '0;
      end
   end

   // DATA register and write counter, committed at the end of the ACK cycle
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         data_q <= C_RESET_VALUE;
         wcount <= '0;
      end else if (wr_data) begin
         data_q <= (data_q & ~wmask) | (wdata & wmask);
         wcount <= wcount + 32'd1;
      end
   end

   // Pending flag and sticky overrun; a new write wins over a clear
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         user_data_valid <= 1'b0;
         overrun         <= 1'b0;
      end else begin
         if (wr_data) begin
            user_data_valid <= 1'b1;
         end else if (user_ack && user_data_valid) begin
            user_data_valid <= 1'b0;
         end

         if (wr_data && user_data_valid && !user_ack) begin
            overrun <= 1'b1;
         end else if (wr_status && wdata[STATUS_OVERRUN_BIT]) begin
            overrun <= 1'b0;
         end
      end
   end

   assign Sl_DBus       = sl_dbus_q;
   assign Sl_xferAck    = ack;
   assign Sl_errAck     = 1'b0;
   assign Sl_retry      = 1'b0;
   assign Sl_toutSup    = 1'b0;
   assign user_data_out = data_q;

endmodule

// File: tb/tb_opb_register_ppc2fabric.sv
// Bench for opb_register_ppc2fabric: constant vector table, hand-written
// multi-cycle sequences, and randomized transactions against a
// transaction-level model of the register file.
module tb_opb_register_ppc2fabric;

   localparam logic [31:0] BASE = 32'h0100_E200;
   localparam logic [31:0] HIGH = 32'h0100_E2FF;

   localparam int OP_RD   = 0;
   localparam int OP_WR   = 1;
   localparam int OP_UACK = 2;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [0:31] opb_abus = '0;
   logic [0:3]  opb_be = '0;
   logic [0:31] opb_dbus = '0;
   logic        opb_rnw = 1'b1;
   logic        opb_select = 1'b0;
   logic        opb_seqaddr = 1'b0;
   logic [0:31] sl_dbus;
   logic        sl_xferack;
   logic        sl_errack;
   logic        sl_retry;
   logic        sl_toutsup;
   logic [31:0] user_data_out;
   logic        user_data_valid;
   logic        user_ack = 1'b0;

   opb_register_ppc2fabric dut (
      .OPB_Clk         (clk),
      .OPB_Rst_n       (rst_n),
      .OPB_ABus        (opb_abus),
      .OPB_BE          (opb_be),
      .OPB_DBus        (opb_dbus),
      .OPB_RNW         (opb_rnw),
      .OPB_select      (opb_select),
      .OPB_seqAddr     (opb_seqaddr),
      .Sl_DBus         (sl_dbus),
      .Sl_xferAck      (sl_xferack),
      .Sl_errAck       (sl_errack),
      .Sl_retry        (sl_retry),
      .Sl_toutSup      (sl_toutsup),
      .user_data_out   (user_data_out),
      .user_data_valid (user_data_valid),
      .user_ack        (user_ack)
   );

   // ---------------- scoreboard counters ----------------
   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ovr;
   logic [31:0] m_wcount;

   task automatic model_reset();
      m_data = 32'h0; m_valid = 1'b0; m_ovr = 1'b0; m_wcount = 32'h0;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] off);
      case (off)
         32'h0:   return m_data;
         32'h4:   return {30'b0, m_ovr, m_valid};
         32'h8:   return m_wcount;
         default: return 32'h0;
      endcase
   endfunction

   // Effect of one completed transaction, optionally with user_ack sampled
   // in the same cycle as the write commit
   task automatic model_apply(input logic rnw, input logic [31:0] off, input logic [0:3] be_bus,
                              input logic [31:0] wd, input logic uack);
      if (!rnw && off == 32'h0) begin
         if (m_valid && !uack) m_ovr = 1'b1;
         for (int k = 0; k < 4; k++)
            if (be_bus[k]) m_data[31-8*k -: 8] = wd[31-8*k -: 8];
         m_valid  = 1'b1;
         m_wcount = m_wcount + 32'd1;
      end else begin
         if (!rnw && off == 32'h4 && wd[1]) m_ovr = 1'b0;
         if (uack) m_valid = 1'b0;
      end
   endtask

   // ---------------- driver tasks ----------------
   // One OPB transfer. lat = cycles from select sampled to ack (-1: none).
   task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [0:3] be_bus,
                       input logic [31:0] wd, input logic uack,
                       output logic [31:0] rd, output int lat);
      logic [31:0] bus_v;
      rd  = 32'h0;
      lat = -1;
      @(posedge clk);
      @(negedge clk);
      opb_abus = addr; opb_be = be_bus; opb_dbus = wd; opb_rnw = rnw; opb_select = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         bus_v = sl_dbus;
         if (sl_xferack) begin
            lat = i;
            rd  = bus_v;
            break;
         end
         chk("dbus_zero_no_ack", bus_v, 32'h0);
      end
      // bus held through the ACK cycle; release after its closing edge
      if (lat > 0) begin
         user_ack = uack;
         @(posedge clk); #1;
      end
      user_ack = 1'b0;
      opb_select = 1'b0; opb_rnw = 1'b1; opb_abus = '0; opb_dbus = '0; opb_be = '0;
      bus_v = sl_dbus;
      chk("ack_single_cycle", {31'b0, sl_xferack}, 32'h0);
      chk("dbus_zero_after_ack", bus_v, 32'h0);
   endtask

   task automatic pulse_uack();
      @(negedge clk);
      user_ack = 1'b1;
      @(posedge clk); #1;
      user_ack = 1'b0;
      m_valid = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_dout"}, user_data_out, m_data);
      chk({tag, "_valid"}, {31'b0, user_data_valid}, {31'b0, m_valid});
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          op;
      logic [31:0] off;
      logic [0:3]  be;
      logic [31:0] wd;
      logic        uack;
      logic [31:0] exp_rd;
      logic [31:0] exp_dout;
      logic        exp_valid;
   } vec_t;

   vec_t tbl[21];

   function automatic vec_t mk(input int op, input logic [31:0] off, input logic [0:3] be,
                               input logic [31:0] wd, input logic uack, input logic [31:0] exp_rd,
                               input logic [31:0] exp_dout, input logic exp_valid);
      vec_t v;
      v.op = op; v.off = off; v.be = be; v.wd = wd; v.uack = uack;
      v.exp_rd = exp_rd; v.exp_dout = exp_dout; v.exp_valid = exp_valid;
      return v;
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] rd;
      int          lat;
      int          nack;
      logic [31:0] bus_v;
      logic [31:0] off;
      logic [0:3]  be_r;
      logic [31:0] wd_r;
      logic        ua_r;
      int          sel;

      tbl[0]  = mk(OP_RD,   32'h0,  4'b0000, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0);
      tbl[1]  = mk(OP_RD,   32'h4,  4'b0000, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0);
      tbl[2]  = mk(OP_RD,   32'h8,  4'b0000, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0);
      tbl[3]  = mk(OP_WR,   32'h0,  4'b1111, 32'hDEADBEEF,  1'b0, 32'h0,         32'hDEADBEEF,  1'b1);
      tbl[4]  = mk(OP_RD,   32'h8,  4'b0000, 32'h0,         1'b0, 32'h1,         32'hDEADBEEF,  1'b1);
      tbl[5]  = mk(OP_RD,   32'h4,  4'b0000, 32'h0,         1'b0, 32'h1,         32'hDEADBEEF,  1'b1);
      tbl[6]  = mk(OP_UACK, 32'h0,  4'b0000, 32'h0,         1'b0, 32'h0,         32'hDEADBEEF,  1'b0);
      tbl[7]  = mk(OP_RD,   32'h4,  4'b0000, 32'h0,         1'b0, 32'h0,         32'hDEADBEEF,  1'b0);
      tbl[8]  = mk(OP_WR,   32'h0,  4'b0101, 32'h11223344,  1'b0, 32'h0,         32'hDE22BE44,  1'b1);
      tbl[9]  = mk(OP_WR,   32'h0,  4'b1111, 32'hAAAA5555,  1'b0, 32'h0,         32'hAAAA5555,  1'b1);
      tbl[10] = mk(OP_WR,   32'h0,  4'b1111, 32'h12345678,  1'b0, 32'h0,         32'h12345678,  1'b1);
      tbl[11] = mk(OP_RD,   32'h4,  4'b0000, 32'h0,         1'b0, 32'h3,         32'h12345678,  1'b1);
      tbl[12] = mk(OP_WR,   32'h4,  4'b1111, 32'h2,         1'b0, 32'h0,         32'h12345678,  1'b1);
      tbl[13] = mk(OP_RD,   32'h4,  4'b0000, 32'h0,         1'b0, 32'h1,         32'h12345678,  1'b1);
      tbl[14] = mk(OP_WR,   32'h0,  4'b1111, 32'hCAFEF00D,  1'b1, 32'h0,         32'hCAFEF00D,  1'b1);
      tbl[15] = mk(OP_RD,   32'h4,  4'b0000, 32'h0,         1'b0, 32'h1,         32'hCAFEF00D,  1'b1);
      tbl[16] = mk(OP_RD,   32'h8,  4'b0000, 32'h0,         1'b0, 32'h5,         32'hCAFEF00D,  1'b1);
      tbl[17] = mk(OP_RD,   32'h0,  4'b0000, 32'h0,         1'b0, 32'hCAFEF00D,  32'hCAFEF00D,  1'b1);
      tbl[18] = mk(OP_RD,   32'h10, 4'b0000, 32'h0,         1'b0, 32'h0,         32'hCAFEF00D,  1'b1);
      tbl[19] = mk(OP_WR,   32'h10, 4'b1111, 32'hFFFFFFFF,  1'b0, 32'h0,         32'hCAFEF00D,  1'b1);
      tbl[20] = mk(OP_WR,   32'h0,  4'b0000, 32'h87654321,  1'b0, 32'h0,         32'hCAFEF00D,  1'b1);

      // reset
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {31'b0, sl_xferack}, 32'h0);
      bus_v = sl_dbus;
      chk("rst_dbus", bus_v, 32'h0);
      chk("rst_const", {29'b0, sl_errack, sl_retry, sl_toutsup}, 32'h0);
      check_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // table-driven vectors
      for (int i = 0; i < 21; i++) begin
         if (tbl[i].op == OP_UACK) begin
            pulse_uack();
         end else begin
            xfer(tbl[i].op == OP_RD, BASE + tbl[i].off, tbl[i].be, tbl[i].wd, tbl[i].uack, rd, lat);
            chk($sformatf("tbl%0d_latency", i), lat, 32'd1);
            if (tbl[i].op == OP_RD) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            model_apply(tbl[i].op == OP_RD, tbl[i].off, tbl[i].be, tbl[i].wd, tbl[i].uack);
         end
         chk($sformatf("tbl%0d_dout", i), user_data_out, tbl[i].exp_dout);
         chk($sformatf("tbl%0d_valid", i), {31'b0, user_data_valid}, {31'b0, tbl[i].exp_valid});
      end
      // the zero-BE write still counted and was an overrun
      xfer(1'b1, BASE + 32'h8, 4'b0000, 32'h0, 1'b0, rd, lat);
      chk("be0_wcount", rd, 32'h6);
      xfer(1'b1, BASE + 32'h4, 4'b0000, 32'h0, 1'b0, rd, lat);
      chk("be0_status", rd, 32'h3);

      // select held high: acks only at cycles 1, 4, 7
      @(posedge clk);
      @(negedge clk);
      opb_abus = BASE; opb_rnw = 1'b1; opb_be = 4'b1111; opb_select = 1'b1;
      nack = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         bus_v = sl_dbus;
         if (sl_xferack) nack++;
         chk($sformatf("hold_ack_c%0d", c), {31'b0, sl_xferack},
             {31'b0, (c == 1 || c == 4 || c == 7)});
         chk($sformatf("hold_dbus_c%0d", c), bus_v, sl_xferack ? m_data : 32'h0);
         if (c == 8) begin
            @(negedge clk);
            opb_select = 1'b0;
         end
      end
      chk("hold_ack_count", nack, 32'd3);

      // window edges
      xfer(1'b1, HIGH + 32'd4, 4'b1111, 32'h0, 1'b0, rd, lat);
      chk("oow_high_noack", lat, -32'sd1);
      xfer(1'b0, BASE - 32'd4, 4'b1111, 32'hFFFFFFFF, 1'b0, rd, lat);
      chk("oow_low_noack", lat, -32'sd1);
      check_outputs("oow");
      xfer(1'b1, HIGH - 32'd3, 4'b1111, 32'h0, 1'b0, rd, lat);
      chk("edge_high_latency", lat, 32'd1);
      chk("edge_high_rdata", rd, 32'h0);

      // randomized transactions against the model
      for (int n = 0; n < 120; n++) begin
         sel  = $urandom_range(0, 6);
         be_r = 4'($urandom_range(0, 15));
         wd_r = $urandom;
         ua_r = ($urandom_range(0, 3) == 0);
         case (sel)
            0, 1:    off = 32'($urandom_range(0, 3)) * 4;
            2, 3:    off = 32'h0;
            4:       off = 32'h4;
            default: off = 32'($urandom_range(3, 63)) * 4;
         endcase
         if (sel == 6) begin
            pulse_uack();
         end else begin
            xfer(sel <= 1, BASE + off, be_r, wd_r, ua_r, rd, lat);
            chk("rnd_latency", lat, 32'd1);
            if (sel <= 1) chk($sformatf("rnd_rd_off%0h", off), rd, model_read(off));
            model_apply(sel <= 1, off, be_r, wd_r, ua_r);
         end
         check_outputs("rnd");
         if (n % 10 == 9) begin
            xfer(1'b1, BASE + 32'h4, 4'b0000, 32'h0, 1'b0, rd, lat);
            chk("rnd_status", rd, model_read(32'h4));
         end
      end

      // reset asserted during the ACK cycle of a DATA write
      @(posedge clk);
      @(negedge clk);
      opb_abus = BASE; opb_rnw = 1'b0; opb_be = 4'b1111; opb_dbus = 32'h55AA_55AA; opb_select = 1'b1;
      @(posedge clk); #1;
      chk("rstmid_ack_seen", {31'b0, sl_xferack}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      bus_v = sl_dbus;
      chk("rstmid_ack_drop", {31'b0, sl_xferack}, 32'h0);
      chk("rstmid_dbus", bus_v, 32'h0);
      model_reset();
      check_outputs("rstmid");
      @(negedge clk);
      opb_select = 1'b0; opb_rnw = 1'b1; opb_dbus = '0;
      @(negedge clk);
      rst_n = 1'b1;
      check_outputs("rstmid_after");
      xfer(1'b1, BASE + 32'h8, 4'b0000, 32'h0, 1'b0, rd, lat);
      chk("rstmid_wcount", rd, 32'h0);

      // WCOUNT wrap: preload the counter, then one more DATA write
      @(negedge clk);
      force dut.wcount = 32'hFFFF_FFFF;
      #1;
      release dut.wcount;
      m_wcount = 32'hFFFF_FFFF;
      xfer(1'b1, BASE + 32'h8, 4'b0000, 32'h0, 1'b0, rd, lat);
      chk("wrap_pre", rd, 32'hFFFF_FFFF);
      xfer(1'b0, BASE, 4'b1111, 32'h0BAD_F00D, 1'b0, rd, lat);
      model_apply(1'b0, 32'h0, 4'b1111, 32'h0BAD_F00D, 1'b0);
      xfer(1'b1, BASE + 32'h8, 4'b0000, 32'h0, 1'b0, rd, lat);
      chk("wrap_post", rd, model_read(32'h8));
      chk("wrap_zero", rd, 32'h0);
      check_outputs("wrap");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
